// File: rtl/mdu.sv
// mdu: multi-cycle RV64M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Optional MDU_EARLY_OUT_EN: 1-cycle divide-by-zero, signed overflow and zero-operand multiply.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef EXU_OPT_WIDTH
`define EXU_OPT_WIDTH 5
`endif
`ifndef ALU_MUL
`define ALU_MUL    5'd16
`define ALU_MULH   5'd17
`define ALU_MULHSU 5'd18
`define ALU_MULHU  5'd19
`define ALU_MULW   5'd20
`define ALU_DIV    5'd21
`define ALU_DIVU   5'd22
`define ALU_REM    5'd23
`define ALU_REMU   5'd24
`define ALU_DIVW   5'd25
`define ALU_DIVUW  5'd26
`define ALU_REMW   5'd27
`define ALU_REMUW  5'd28
`endif

// Handshakes: a transfer happens on a rising edge where valid && ready; the
// request side is ready only in IDLE, the response is held until i_ready.
module mdu (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [`CPU_WIDTH-1:0]     i_src1,
    input  logic [`CPU_WIDTH-1:0]     i_src2,
    input  logic [`EXU_OPT_WIDTH-1:0] i_opt,
    input  logic                      i_flush,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [`CPU_WIDTH-1:0]     o_res,
    output logic [1:0]                o_dbg_state
);
    localparam int W  = `CPU_WIDTH;
    localparam int HW = W / 2;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0] cnt_q;
    logic [W-1:0]  a_q, hi_q, lo_q, res_q, early_val_q;
    logic          is_mul_q, is_w_q, hi_sel_q, rem_q, early_q;
    logic          prod_neg_q, q_neg_q, r_neg_q;

    logic dec_ok, dec_mul, dec_w, dec_s1, dec_s2, dec_hi, dec_rem;
    always_comb begin
        dec_ok  = 1'b1;
        dec_mul = 1'b0;
        dec_w   = 1'b0;
        dec_s1  = 1'b0;
        dec_s2  = 1'b0;
        dec_hi  = 1'b0;
        dec_rem = 1'b0;
        case (i_opt)
            `ALU_MUL:    dec_mul = 1'b1;
            `ALU_MULH:   begin dec_mul = 1'b1; dec_hi = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            `ALU_MULHSU: begin dec_mul = 1'b1; dec_hi = 1'b1; dec_s1 = 1'b1; end
            `ALU_MULHU:  begin dec_mul = 1'b1; dec_hi = 1'b1; end
            `ALU_MULW:   begin dec_mul = 1'b1; dec_w = 1'b1; end
            `ALU_DIV:    begin dec_s1 = 1'b1; dec_s2 = 1'b1; end
            `ALU_DIVU:   begin end
            `ALU_REM:    begin dec_rem = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            `ALU_REMU:   dec_rem = 1'b1;
            `ALU_DIVW:   begin dec_w = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            `ALU_DIVUW:  dec_w = 1'b1;
            `ALU_REMW:   begin dec_w = 1'b1; dec_rem = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
            `ALU_REMUW:  begin dec_w = 1'b1; dec_rem = 1'b1; end
            default:     dec_ok = 1'b0;
        endcase
    end

    // Operands are reduced to magnitudes; signs are reapplied after the last iteration.
    logic [W-1:0] op1, op2, mag1, mag2, op1_min, src1_sx, early_val;
    logic         neg1, neg2, div_zero, div_ovf, mul_zero, early_hit;
    always_comb begin
        op1 = i_src1;
        op2 = i_src2;
        if (dec_w) begin
            op1 = {{HW{dec_s1 & i_src1[HW-1]}}, i_src1[HW-1:0]};
            op2 = {{HW{dec_s2 & i_src2[HW-1]}}, i_src2[HW-1:0]};
        end
        neg1     = dec_s1 & op1[W-1];
        neg2     = dec_s2 & op2[W-1];
        mag1     = neg1 ? -op1 : op1;
        mag2     = neg2 ? -op2 : op2;
        op1_min  = dec_w ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
        src1_sx  = dec_w ? {{HW{i_src1[HW-1]}}, i_src1[HW-1:0]} : i_src1;
        div_zero = !dec_mul && (op2 == '0);
        div_ovf  = !dec_mul && dec_s1 && (op1 == op1_min) && (op2 == '1);
        mul_zero = dec_mul && ((op1 == '0) || (op2 == '0));
        early_val = '0;
        if (!dec_ok || mul_zero)
            early_val = '0;
        else if (div_zero)
            early_val = dec_rem ? src1_sx : '1;
        else if (div_ovf)
            early_val = dec_rem ? '0 : op1;
`ifdef MDU_EARLY_OUT_EN
        early_hit = !dec_ok || div_zero || div_ovf || mul_zero;
`else
        early_hit = !dec_ok;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_valid) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  if (i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_flush)
            state_d = S_IDLE;
    end

    logic accept;
    assign o_ready     = (state_q == S_IDLE);
    assign o_valid     = (state_q == S_DONE);
    assign o_res       = res_q;
    assign o_dbg_state = state_q;
    assign accept      = o_ready && i_valid && !i_flush;

    logic [W:0] mul_sum, div_shift, div_diff;
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = div_shift - {1'b0, a_q};
    end

    // W multiplies run 32 steps, leaving the product shifted up by HW bits.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo, quo_fix, rem_fix, raw, fix_res;
    always_comb begin
        prod_fix = prod_neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo      = is_w_q ? {{HW{1'b0}}, lo_q[HW-1:0]} : lo_q;
        quo_fix  = q_neg_q ? -quo : quo;
        rem_fix  = r_neg_q ? -hi_q : hi_q;
        raw      = '0;
        if (early_q)
            raw = early_val_q;
        else if (is_mul_q)
            raw = hi_sel_q ? prod_fix[2*W-1:W]
                           : (is_w_q ? {{HW{1'b0}}, prod_fix[W-1:HW]} : prod_fix[W-1:0]);
        else
            raw = rem_q ? rem_fix : quo_fix;
        fix_res = is_w_q ? {{HW{raw[HW-1]}}, raw[HW-1:0]} : raw;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            a_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            res_q       <= '0;
            early_val_q <= '0;
            is_mul_q    <= 1'b0;
            is_w_q      <= 1'b0;
            hi_sel_q    <= 1'b0;
            rem_q       <= 1'b0;
            early_q     <= 1'b0;
            prod_neg_q  <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
        end else if (accept) begin
            is_mul_q    <= dec_mul;
            is_w_q      <= dec_w;
            hi_sel_q    <= dec_hi;
            rem_q       <= dec_rem;
            early_q     <= early_hit;
            early_val_q <= early_val;
            cnt_q       <= early_hit ? '0 : (dec_w ? CW'(HW) : CW'(W));
            hi_q        <= '0;
            prod_neg_q  <= neg1 ^ neg2;
            q_neg_q     <= (neg1 ^ neg2) && !div_zero;
            r_neg_q     <= neg1;
            if (dec_mul) begin
                a_q  <= mag1;
                lo_q <= mag2;
            end else begin
                a_q  <= mag2;
                lo_q <= dec_w ? {mag1[HW-1:0], {HW{1'b0}}} : mag1;
            end
        end else if (state_q == S_BUSY) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
                if (is_mul_q) begin
                    hi_q <= mul_sum[W:1];
                    lo_q <= {mul_sum[0], lo_q[W-1:1]};
                end else if (!div_diff[W]) begin
                    hi_q <= div_diff[W-1:0];
                    lo_q <= {lo_q[W-2:0], 1'b1};
                end else begin
                    hi_q <= div_shift[W-1:0];
                    lo_q <= {lo_q[W-2:0], 1'b0};
                end
            end else if (!i_flush) begin
                res_q <= fix_res;
            end
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: vector table, randomized ops against an arithmetic reference model, and
// hand-written back-pressure / flush / reset sequences for mdu.
module tb_mdu;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_MULW = 5'd20, OP_DIV = 5'd21, OP_DIVU = 5'd22, OP_REM = 5'd23;
  localparam logic [4:0] OP_REMU = 5'd24, OP_DIVW = 5'd25, OP_DIVUW = 5'd26, OP_REMW = 5'd27;
  localparam logic [4:0] OP_REMUW = 5'd28, OP_BAD = 5'd0;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef MDU_EARLY_OUT_EN
  localparam int E64 = 1;
  localparam int E32 = 1;
`else
  localparam int E64 = 65;
  localparam int E32 = 33;
`endif

  logic        clk, rst_n, i_valid, o_ready, i_flush, o_valid, i_ready;
  logic [63:0] i_src1, i_src2, o_res;
  logic [4:0]  i_opt;
  logic [1:0]  dbg_state;

  int total, bad;
  logic [63:0] exp_q[$];
  int          lat_q[$];

  mdu dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_src1(i_src1), .i_src2(i_src2), .i_opt(i_opt), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res), .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic bit is_w_op(input logic [4:0] op);
    return op == OP_MULW || op == OP_DIVW || op == OP_DIVUW || op == OP_REMW || op == OP_REMUW;
  endfunction

  function automatic bit is_mul_op(input logic [4:0] op);
    return op >= OP_MUL && op <= OP_MULW;
  endfunction

  // Reference: the RISC-V M results written directly with wide arithmetic.
  function automatic logic [63:0] ref_res(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, za, zb, p;
    logic signed [63:0] s1, s2;
    logic signed [31:0] w1, w2;
    logic [31:0] u1, u2;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    za = {64'd0, a};
    zb = {64'd0, b};
    s1 = a;
    s2 = b;
    u1 = a[31:0];
    u2 = b[31:0];
    w1 = u1;
    w2 = u2;
    case (op)
      OP_MUL:    begin p = za * zb; return p[63:0]; end
      OP_MULH:   begin p = sa * sb; return p[127:64]; end
      OP_MULHSU: begin p = sa * zb; return p[127:64]; end
      OP_MULHU:  begin p = za * zb; return p[127:64]; end
      OP_MULW:   return sx32(u1 * u2);
      OP_DIV:    if (b == 0) return ONES; else if (a == MIN64 && b == ONES) return a; else return s1 / s2;
      OP_DIVU:   if (b == 0) return ONES; else return a / b;
      OP_REM:    if (b == 0) return a; else if (a == MIN64 && b == ONES) return 64'd0; else return s1 % s2;
      OP_REMU:   if (b == 0) return a; else return a % b;
      OP_DIVW:   if (u2 == 0) return ONES; else if (u1 == 32'h8000_0000 && u2 == 32'hFFFF_FFFF) return sx32(u1);
                 else return sx32(w1 / w2);
      OP_DIVUW:  if (u2 == 0) return ONES; else return sx32(u1 / u2);
      OP_REMW:   if (u2 == 0) return sx32(u1); else if (u1 == 32'h8000_0000 && u2 == 32'hFFFF_FFFF) return 64'd0;
                 else return sx32(w1 % w2);
      OP_REMUW:  if (u2 == 0) return sx32(u1); else return sx32(u1 % u2);
      default:   return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [63:0] x, y;
    bit sgn;
`endif
    if (op < OP_MUL || op > OP_REMUW) return 1;
`ifdef MDU_EARLY_OUT_EN
    x = is_w_op(op) ? {32'd0, a[31:0]} : a;
    y = is_w_op(op) ? {32'd0, b[31:0]} : b;
    sgn = (op == OP_DIV || op == OP_REM || op == OP_DIVW || op == OP_REMW);
    if (is_mul_op(op) && (x == 0 || y == 0)) return 1;
    if (!is_mul_op(op) && y == 0) return 1;
    if (sgn && !is_w_op(op) && x == MIN64 && y == ONES) return 1;
    if (sgn && is_w_op(op) && x == 64'h8000_0000 && y == 64'hFFFF_FFFF) return 1;
`endif
    return is_w_op(op) ? 33 : 65;
  endfunction

  // Issue one request, count edges from accept to o_valid, then pop the result after 'hold' stall cycles.
  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int hold, output logic [63:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!o_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!o_ready) check_int("ready_timeout", 0, 1);
    i_valid = 1'b1;
    i_opt = op;
    i_src1 = a;
    i_src2 = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!o_valid && lat < 200);
    res = o_res;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    i_valid = 1'b1;
    i_opt = op;
    i_src1 = a;
    i_src2 = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES;
      2: return MIN64;
      3: return 64'($urandom_range(0, 20));
      4: return 64'h0000_0000_8000_0000;
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[21];
  logic [4:0] ops[13];

  initial begin
    logic [63:0] got;
    int lat, pulses, first_lat;
    logic [63:0] first_res;

    total = 0;
    bad = 0;
    vecs[0]  = '{OP_MUL,    64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65};
    vecs[1]  = '{OP_MULH,   64'd3, 64'hFFFF_FFFF_FFFF_FFFB, ONES, 65};
    vecs[2]  = '{OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65};
    vecs[4]  = '{OP_DIVUW,  64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
    vecs[5]  = '{OP_DIV,    64'd5, 64'd0, ONES, E64};
    vecs[6]  = '{OP_REM,    64'd5, 64'd0, 64'd5, E64};
    vecs[7]  = '{OP_DIV,    MIN64, ONES, MIN64, E64};
    vecs[8]  = '{OP_REM,    MIN64, ONES, 64'd0, E64};
    vecs[9]  = '{OP_MULHU,  ONES, 64'd2, 64'd1, 65};
    vecs[10] = '{OP_MULHSU, ONES, 64'd2, ONES, 65};
    vecs[11] = '{OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[12] = '{OP_REMW,   64'h1234_5678_FFFF_FFF9, 64'd2, ONES, 33};
    vecs[13] = '{OP_DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, E32};
    vecs[14] = '{OP_DIVU,   64'd100, 64'd7, 64'd14, 65};
    vecs[15] = '{OP_REMUW,  64'hAAAA_AAAA_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, ONES, E32};
    vecs[16] = '{OP_BAD,    64'h55, 64'h66, 64'd0, 1};
    vecs[17] = '{OP_MUL,    64'd0, 64'd12345, 64'd0, E64};
    vecs[18] = '{OP_MULH,   ONES, MIN64, 64'd0, 65};
    vecs[19] = '{OP_DIVUW,  64'd7, 64'h1234_5678_0000_0002, 64'd3, 33};
    vecs[20] = '{OP_REMU,   64'd100, 64'd7, 64'd2, 65};
    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW, OP_DIV, OP_DIVU,
            OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};

    // Clock/reset
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    i_opt = OP_BAD;
    i_src1 = '0;
    i_src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check64("reset_ready", {63'd0, o_ready}, 64'd1);
    check64("reset_valid", {63'd0, o_valid}, 64'd0);
    check64("reset_res", o_res, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, got, lat);
      check64($sformatf("vec%0d_res", i), got, vecs[i].res);
      check_int($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    for (int i = 0; i < 150; i++) begin
      logic [4:0] op;
      logic [63:0] a, b;
      op = ops[$urandom_range(0, 12)];
      a = pick_operand();
      b = pick_operand();
      exp_q.push_back(ref_res(op, a, b));
      lat_q.push_back(ref_lat(op, a, b));
      run_op(op, a, b, $urandom_range(0, 2), got, lat);
      check64($sformatf("rand%0d_res op=%0d a=%h b=%h", i, op, a, b), got, exp_q.pop_front());
      check_int($sformatf("rand%0d_lat", i), lat, lat_q.pop_front());
      check_int("dbg_state_legal", int'(dbg_state != 2'b11), 1);
    end

    // Back-pressure: result must hold while i_ready is low.
    issue(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    lat = 0;
    while (!o_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_int("bp_lat", lat, 65);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check64("bp_valid", {63'd0, o_valid}, 64'd1);
      check64("bp_res", o_res, 64'hFFFF_FFFF_FFFF_FFFD);
      check64("bp_ready", {63'd0, o_ready}, 64'd0);
    end
    @(negedge clk);
    i_ready = 1'b1;
    check64("bp_ready_same_cycle", {63'd0, o_ready}, 64'd0);
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check64("bp_ready_after", {63'd0, o_ready}, 64'd1);
    check64("bp_valid_after", {63'd0, o_valid}, 64'd0);

    // Flush in BUSY, then an immediate new request: exactly one response.
    issue(OP_DIV, 64'd1000, 64'd3);
    repeat (19) @(posedge clk);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    check64("flush_busy_valid", {63'd0, o_valid}, 64'd0);
    check64("flush_busy_ready", {63'd0, o_ready}, 64'd1);
    @(negedge clk);
    i_flush = 1'b0;
    i_ready = 1'b1;
    issue(OP_MULHU, ONES, 64'd2);
    pulses = 0;
    first_lat = 0;
    first_res = '0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        if (pulses == 0) begin
          first_lat = c;
          first_res = o_res;
        end
        pulses++;
      end
    end
    i_ready = 1'b0;
    check_int("flush_pulses", pulses, 1);
    check64("flush_new_res", first_res, 64'd1);
    check_int("flush_new_lat", first_lat, 65);

    // Flush in DONE drops the result; flush beats a simultaneous request in IDLE.
    issue(OP_MUL, 64'd3, 64'd4);
    lat = 0;
    while (!o_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check64("done_res", o_res, 64'd12);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    check64("flush_done_valid", {63'd0, o_valid}, 64'd0);
    check64("flush_done_ready", {63'd0, o_ready}, 64'd1);
    @(negedge clk);
    i_valid = 1'b1;
    i_opt = OP_BAD;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    check64("flush_beats_valid_ready", {63'd0, o_ready}, 64'd1);
    @(posedge clk);
    #1;
    check64("flush_beats_valid_valid", {63'd0, o_valid}, 64'd0);

    // Reset mid-divide.
    issue(OP_DIV, 64'd1000, 64'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check64("rst_mid_valid", {63'd0, o_valid}, 64'd0);
    check64("rst_mid_ready", {63'd0, o_ready}, 64'd1);
    check64("rst_mid_res", o_res, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_DIVU, 64'd100, 64'd7, 0, got, lat);
    check64("post_rst_res", got, 64'd14);
    check_int("post_rst_lat", lat, 65);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
